// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run/step/halt sequencer for the debug-mode MIPS pipeline.
// Owns the pipeline advance enable and the instruction-RAM load select,
// executes debug commands from the SPI slave and drains the pipeline after
// the HALT word reaches IF/ID.
// Optional feature: define DEBUG_BREAKPOINT_EN to build the PC breakpoint.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing running, program may or may not be resident
// LOAD   | SPI owns instruction RAM, pipeline frozen
// RUN    | free run, enable high every cycle
// STEP   | enable high for a counted number of cycles
// PAUSED | pipeline frozen, waiting for resume
// DRAIN  | HALT seen at IF/ID, flushing the pipeline for DRAIN_CYCLES
// DONE   | program finished

module debug_run_ctrl #(
    parameter int unsigned NB_BITS = 32,
    parameter logic [NB_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [2:0]         i_cmd,
    input  logic               i_cmd_valid,
    input  logic [NB_BITS-1:0] i_cmd_arg,
    input  logic [NB_BITS-1:0] i_pc,
    input  logic [NB_BITS-1:0] i_if_id_instr,
    output logic               o_debug_enb,
    output logic               o_cs_debug,
    output logic               o_done,
    output logic [2:0]         o_state,
    output logic [NB_BITS-1:0] o_run_cycles,
    output logic               o_cmd_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_PAUSED = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_LOAD   = 3'd1;
    localparam logic [2:0] CMD_RUN    = 3'd2;
    localparam logic [2:0] CMD_STEP   = 3'd3;
    localparam logic [2:0] CMD_PAUSE  = 3'd4;
    localparam logic [2:0] CMD_SET_BP = 3'd5;
    localparam logic [2:0] CMD_CLR_BP = 3'd6;
    localparam logic [2:0] CMD_ABORT  = 3'd7;

    localparam logic [NB_BITS-1:0] ONE_W      = {{(NB_BITS-1){1'b0}}, 1'b1};
    localparam logic [NB_BITS-1:0] ALL_ONES_W = {NB_BITS{1'b1}};
    localparam logic [3:0]         DRAIN_LOAD = 4'(DRAIN_CYCLES);

`ifdef DEBUG_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    state_t             state;
    state_t             next_state;
    state_t             cmd_target;
    logic               cmd_legal;
    logic               cmd_go;
    logic               cmd_hit;
    logic               abort_req;
    logic               halt_det;
    logic               bp_hit;
    logic [NB_BITS-1:0] step_cnt;
    logic [NB_BITS-1:0] step_cnt_nxt;
    logic [3:0]         drain_cnt;
    logic [3:0]         drain_cnt_nxt;
    logic [NB_BITS-1:0] run_cycles;

    assign o_state      = state;
    assign o_run_cycles = run_cycles;

    // Command legality table: which commands are accepted here and where they lead.
    always_comb begin
        cmd_legal  = 1'b0;
        cmd_go     = 1'b0;
        cmd_target = state;
        case (i_cmd)
            CMD_NOP: cmd_legal = 1'b1;
            CMD_ABORT: begin
                cmd_legal  = 1'b1;
                cmd_go     = 1'b1;
                cmd_target = ST_IDLE;
            end
            CMD_SET_BP, CMD_CLR_BP: cmd_legal = BP_EN;
            CMD_LOAD: begin
                if (state inside {ST_IDLE, ST_PAUSED, ST_DONE}) begin
                    cmd_legal  = 1'b1;
                    cmd_go     = 1'b1;
                    cmd_target = ST_LOAD;
                end
            end
            CMD_RUN: begin
                if (state inside {ST_IDLE, ST_LOAD, ST_PAUSED}) begin
                    cmd_legal  = 1'b1;
                    cmd_go     = 1'b1;
                    cmd_target = ST_RUN;
                end
            end
            CMD_STEP: begin
                if (state inside {ST_IDLE, ST_LOAD, ST_PAUSED}) begin
                    cmd_legal  = 1'b1;
                    cmd_go     = 1'b1;
                    cmd_target = ST_STEP;
                end
            end
            CMD_PAUSE: begin
                if (state inside {ST_RUN, ST_STEP}) begin
                    cmd_legal  = 1'b1;
                    cmd_go     = 1'b1;
                    cmd_target = ST_PAUSED;
                end else if (state == ST_DRAIN) begin
                    // the drain must complete; pause is swallowed silently
                    cmd_legal = 1'b1;
                end
            end
            default: cmd_legal = 1'b0;
        endcase
    end

    assign cmd_hit   = i_cmd_valid && cmd_legal && cmd_go;
    assign abort_req = i_cmd_valid && (i_cmd == CMD_ABORT);
    assign halt_det  = o_debug_enb && (state inside {ST_RUN, ST_STEP})
                       && (i_if_id_instr == HALT_WORD);

    // Next state and timer loads; abort beats halt, halt beats everything else.
    always_comb begin
        next_state    = state;
        step_cnt_nxt  = step_cnt;
        drain_cnt_nxt = drain_cnt;
        if (abort_req) begin
            next_state = ST_IDLE;
        end else if (halt_det) begin
            next_state    = ST_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
        end else if (cmd_hit) begin
            next_state = cmd_target;
            if (cmd_target == ST_STEP) begin
                step_cnt_nxt = (i_cmd_arg == '0) ? ONE_W : i_cmd_arg;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (bp_hit) next_state = ST_PAUSED;
                end
                ST_STEP: begin
                    step_cnt_nxt = step_cnt - ONE_W;
                    if (step_cnt == ONE_W) next_state = ST_PAUSED;
                end
                ST_DRAIN: begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                    if (drain_cnt == 4'd1) next_state = ST_DONE;
                end
                default: next_state = state;
            endcase
        end
    end

    // State register, timers and registered outputs derived from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            step_cnt     <= '0;
            drain_cnt    <= '0;
            run_cycles   <= '0;
            o_debug_enb  <= 1'b0;
            o_cs_debug   <= 1'b0;
            o_done       <= 1'b0;
            o_cmd_err    <= 1'b0;
        end else begin
            state       <= next_state;
            step_cnt    <= step_cnt_nxt;
            drain_cnt   <= drain_cnt_nxt;
            o_debug_enb <= next_state inside {ST_RUN, ST_STEP, ST_DRAIN};
            o_cs_debug  <= (next_state == ST_LOAD);
            o_done      <= (next_state == ST_DONE);
            o_cmd_err   <= i_cmd_valid && !cmd_legal;
            if (next_state == ST_LOAD && state != ST_LOAD) begin
                run_cycles <= '0;
            end else if (o_debug_enb && run_cycles != ALL_ONES_W) begin
                run_cycles <= run_cycles + ONE_W;
            end
        end
    end

`ifdef DEBUG_BREAKPOINT_EN
    logic [NB_BITS-1:0] bp_addr;
    logic               bp_valid;
    logic               bp_skip;

    // Breakpoint register; bp_skip lets the first enabled cycle after a resume
    // execute past the address that caused the pause.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            bp_skip  <= 1'b0;
        end else begin
            if (i_cmd_valid && i_cmd == CMD_SET_BP) begin
                bp_addr  <= i_cmd_arg;
                bp_valid <= 1'b1;
            end else if (i_cmd_valid && i_cmd == CMD_CLR_BP) begin
                bp_valid <= 1'b0;
            end
            if (state == ST_PAUSED && (next_state == ST_RUN || next_state == ST_STEP)) begin
                bp_skip <= 1'b1;
            end else if (o_debug_enb) begin
                bp_skip <= 1'b0;
            end
        end
    end

    assign bp_hit = (state == ST_RUN) && bp_valid && !bp_skip && (i_pc == bp_addr);
`else
    logic unused_pc;
    assign unused_pc = ^i_pc;
    assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: directed scenarios with literal
// expectations followed by randomized commands, all checked every cycle
// against a command-table reference model.
`timescale 1ns/1ps

module tb_debug_run_ctrl;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          DRAIN = 4;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3,
                   M_PAUSED = 4, M_DRAIN = 5, M_DONE = 6;
    localparam logic [2:0] C_NOP = 0, C_LOAD = 1, C_RUN = 2, C_STEP = 3,
                           C_PAUSE = 4, C_SET_BP = 5, C_CLR_BP = 6, C_ABORT = 7;

`ifdef DEBUG_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [31:0] arg, pc, instr;
    logic        dbg_enb, cs_debug, done, cmd_err;
    logic [2:0]  state;
    logic [31:0] run_cycles;

    always #5 clk = ~clk;

    debug_run_ctrl #(.NB_BITS(32), .HALT_WORD(HALT), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
        .i_cmd_arg(arg), .i_pc(pc), .i_if_id_instr(instr),
        .o_debug_enb(dbg_enb), .o_cs_debug(cs_debug), .o_done(done),
        .o_state(state), .o_run_cycles(run_cycles), .o_cmd_err(cmd_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode, m_left, m_since;
    logic [31:0] m_cycles, m_bp;
    bit          m_bpv, m_err;

    function automatic bit enabled(input int mode);
        return mode == M_RUN || mode == M_STEP || mode == M_DRAIN;
    endfunction

    function automatic bit legal(input int mode, input logic [2:0] c);
        case (c)
            C_NOP, C_ABORT:     return 1'b1;
            C_SET_BP, C_CLR_BP: return BP_ON;
            C_LOAD:             return mode == M_IDLE || mode == M_PAUSED || mode == M_DONE;
            C_RUN, C_STEP:      return mode == M_IDLE || mode == M_LOAD || mode == M_PAUSED;
            C_PAUSE:            return mode == M_RUN || mode == M_STEP || mode == M_DRAIN;
            default:            return 1'b0;
        endcase
    endfunction

    // destination of a legal command, -1 when it leaves the mode alone
    function automatic int dest(input int mode, input logic [2:0] c);
        case (c)
            C_ABORT: return M_IDLE;
            C_LOAD:  return M_LOAD;
            C_RUN:   return M_RUN;
            C_STEP:  return M_STEP;
            C_PAUSE: return (mode == M_DRAIN) ? -1 : M_PAUSED;
            default: return -1;
        endcase
    endfunction

    int nm, d;
    bit en, halt, ok, hit;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_left = 0; m_since = 1;
            m_cycles = 0; m_bp = 0; m_bpv = 0; m_err = 0;
        end else begin
            en   = enabled(m_mode);
            halt = (m_mode == M_RUN || m_mode == M_STEP) && instr == HALT;
            ok   = legal(m_mode, cmd);
            d    = ok ? dest(m_mode, cmd) : -1;
            hit  = BP_ON && m_mode == M_RUN && m_bpv && pc == m_bp && m_since != 0;
            m_err = cmd_valid && !ok;
            nm = m_mode;
            if (cmd_valid && cmd == C_ABORT) nm = M_IDLE;
            else if (halt) begin nm = M_DRAIN; m_left = DRAIN; end
            else if (cmd_valid && d >= 0) begin
                nm = d;
                if (d == M_STEP) m_left = (arg == 0) ? 1 : int'(arg);
            end else if (m_mode == M_STEP) begin
                m_left--;
                if (m_left == 0) nm = M_PAUSED;
            end else if (m_mode == M_DRAIN) begin
                m_left--;
                if (m_left == 0) nm = M_DONE;
            end else if (hit) nm = M_PAUSED;
            if (cmd_valid && ok && cmd == C_SET_BP) begin m_bp = arg; m_bpv = 1; end
            if (cmd_valid && ok && cmd == C_CLR_BP) m_bpv = 0;
            if (en && m_cycles != 32'hFFFF_FFFF) m_cycles++;
            if (nm == M_LOAD && m_mode != M_LOAD) m_cycles = 0;
            if (en && m_since < 1000) m_since++;
            if (m_mode == M_PAUSED && (nm == M_RUN || nm == M_STEP)) m_since = 0;
            m_mode = nm;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("state",      32'(state),    32'(m_mode));
            cmp("debug_enb",  32'(dbg_enb),  32'(enabled(m_mode)));
            cmp("cs_debug",   32'(cs_debug), 32'(m_mode == M_LOAD));
            cmp("done",       32'(done),     32'(m_mode == M_DONE));
            cmp("cmd_err",    32'(cmd_err),  32'(m_err));
            cmp("run_cycles", run_cycles,    m_cycles);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cmd(input logic [2:0] c, input logic [31:0] a);
        cmd_valid = 1'b1; cmd = c; arg = a;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = C_NOP;
    endtask

    task automatic count_enb(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!dbg_enb) return;
            n++;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL enb_window: enable still high after %0d cycles, expected it to drop", n);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == s) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL wait_state: state %0d after %0d cycles, expected %0d", state, budget, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int n;
    bit stopped;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; arg = 0; pc = 0; instr = 0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        cmp("rst_state", 32'(state), 0);
        cmp("rst_enb", 32'(dbg_enb), 0);
        cmp("rst_cycles", run_cycles, 0);
        rst = 1'b0;

        // load then abort
        do_cmd(C_LOAD, 0);
        cmp("load_state", 32'(state), 1);
        cmp("load_cs", 32'(cs_debug), 1);
        cmp("load_enb", 32'(dbg_enb), 0);
        cmp("load_cycles", run_cycles, 0);
        do_cmd(C_ABORT, 0);
        cmp("abort_state", 32'(state), 0);

        // step 3 then step 0
        do_cmd(C_LOAD, 0);
        do_cmd(C_STEP, 3);
        count_enb(n);
        cmp("step3_len", 32'(n), 3);
        cmp("step3_state", 32'(state), 4);
        cmp("step3_cycles", run_cycles, 3);
        do_cmd(C_STEP, 0);
        count_enb(n);
        cmp("step0_len", 32'(n), 1);
        cmp("step0_cycles", run_cycles, 4);

        // run to halt, drain, done, illegal run
        do_cmd(C_RUN, 0);
        cmp("run_state", 32'(state), 2);
        repeat (3) @(negedge clk);
        instr = HALT;
        @(negedge clk);
        instr = 0;
        cmp("halt_drain", 32'(state), 5);
        count_enb(n);
        cmp("drain_len", 32'(n), DRAIN);
        cmp("done_flag", 32'(done), 1);
        cmp("done_state", 32'(state), 6);
        do_cmd(C_RUN, 0);
        cmp("done_run_err", 32'(cmd_err), 1);
        @(negedge clk);
        cmp("err_pulse_end", 32'(cmd_err), 0);

        // pause and halt together, pause during drain
        do_cmd(C_LOAD, 0);
        do_cmd(C_RUN, 0);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd = C_PAUSE; instr = HALT;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = C_NOP; instr = 0;
        cmp("pause_halt_state", 32'(state), 5);
        do_cmd(C_PAUSE, 0);
        cmp("drain_pause_err", 32'(cmd_err), 0);
        cmp("drain_pause_state", 32'(state), 5);
        wait_state(3'd6, 20);
        do_cmd(C_ABORT, 0);

        // breakpoint
        do_cmd(C_SET_BP, 32'h10);
`ifdef DEBUG_BREAKPOINT_EN
        cmp("setbp_err", 32'(cmd_err), 0);
        pc = 32'h4;
        do_cmd(C_RUN, 0);
        stopped = 1'b0;
        for (int i = 0; i < 20 && !stopped; i++) begin
            if (state == 3'd4) stopped = 1'b1;
            else begin pc = pc + 4; @(negedge clk); end
        end
        cmp("bp_stop_state", 32'(state), 4);
        cmp("bp_stop_pc", pc, 32'h10);
        do_cmd(C_RUN, 0);
        for (int i = 0; i < 6; i++) begin
            cmp("bp_resume_state", 32'(state), 2);
            pc = pc + 4;
            @(negedge clk);
        end
        do_cmd(C_CLR_BP, 0);
        do_cmd(C_ABORT, 0);
`else
        cmp("setbp_err", 32'(cmd_err), 1);
        cmp("setbp_state", 32'(state), 0);
`endif

        // reset in the middle of a long step
        do_cmd(C_STEP, 100);
        repeat (48) @(negedge clk);
        cmp("step100_state", 32'(state), 3);
        rst = 1'b1; cmd_valid = 1'b1; cmd = C_RUN;
        @(negedge clk);
        cmp("mid_rst_state", 32'(state), 0);
        cmp("mid_rst_enb", 32'(dbg_enb), 0);
        cmp("mid_rst_cycles", run_cycles, 0);
        cmp("mid_rst_done", 32'(done), 0);
        rst = 1'b0; cmd_valid = 1'b0; cmd = C_NOP;

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd       = ($urandom_range(0, 39) == 0) ? C_ABORT : 3'($urandom_range(0, 6));
            arg       = (cmd == C_SET_BP) ? 32'($urandom_range(0, 7) * 4) : 32'($urandom_range(0, 6));
            instr     = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
            pc        = 32'($urandom_range(0, 7) * 4);
            @(negedge clk);
        end
        rst = 1'b0; cmd_valid = 1'b0; cmd = C_NOP; instr = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
